// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - Oversampling UART receiver with 2-of-3 bit voting and a show-ahead receive FIFO
// Optional line-break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_ovs #(
  parameter int MAX_WIDTH   = 8,
  parameter int SAMPLE_RATE = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic [1:0]                    cfg_stop_bits,
  input  logic [15:0]                   cfg_clk_div,
  input  logic                          uart_rx,
  input  logic                          rx_req,
  output logic [MAX_WIDTH-1:0]          rx_data,
  output logic                          rx_ready,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int SW = $clog2(SAMPLE_RATE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = MAX_WIDTH + 2;
  localparam logic [SW-1:0] S_LO  = SW'(SAMPLE_RATE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(SAMPLE_RATE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(SAMPLE_RATE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(SAMPLE_RATE - 1);
  localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t state, next_state;
  logic sync1, sync2, rx_prev, rx_s;
  logic [1:0] settle_q;
  logic [15:0] tick_cnt, div_m1;
  logic tick, at_vote, at_end, start_det, vote, final_stop, push, par_en;
  logic [SW-1:0] smp;
  logic s_a, s_b;
  logic [3:0] nbits, bit_idx;
  logic [1:0] par_mode;
  logic two_stop, stop_idx;
  logic [MAX_WIDTH-1:0] data_q;
  logic par_err_q, frm_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
  logic any_one_q, brk;
`endif

  assign rx_s       = sync2;
  assign div_m1     = (cfg_clk_div == 16'd0) ? 16'd0 : cfg_clk_div - 16'd1;
  assign tick       = (state != IDLE) && (tick_cnt == div_m1);
  assign at_vote    = tick && (smp == S_HI);
  assign at_end     = tick && (smp == S_END);
  // Block edges until the synchronizer and edge flop hold real line values after reset.
  assign start_det  = (state == IDLE) && (settle_q == 2'd3) && rx_prev && !rx_s;
  assign vote       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign par_en     = (par_mode == 2'b01) || (par_mode == 2'b10);
  assign final_stop = (state == STOP) && at_vote && (!two_stop || stop_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk        = 1'b0;
`endif
    case (state)
      IDLE:   if (start_det) next_state = START;
      START:  if (at_vote && vote) next_state = IDLE;
              else if (at_end) next_state = DATA;
      DATA:   if (at_end && bit_idx == nbits) next_state = par_en ? PARITY : STOP;
      PARITY: if (at_end) next_state = STOP;
      STOP: if (final_stop) begin
`ifdef UART_RX_BREAK_DETECT_EN
        if (!any_one_q && !vote) begin
          brk        = 1'b1;
          next_state = BRK_WAIT;
        end else begin
          push       = 1'b1;
          next_state = IDLE;
        end
`else
        push       = 1'b1;
        next_state = IDLE;
`endif
      end
`ifdef UART_RX_BREAK_DETECT_EN
      BRK_WAIT: if (rx_s) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1; sync2 <= 1'b1; rx_prev <= 1'b1; settle_q <= 2'd0;
      tick_cnt <= '0; smp <= '0; s_a <= 1'b1; s_b <= 1'b1;
      nbits <= 4'd8; par_mode <= 2'b00; two_stop <= 1'b0;
      bit_idx <= '0; stop_idx <= 1'b0; data_q <= '0;
      par_err_q <= 1'b0; frm_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      any_one_q <= 1'b0;
`endif
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 16'd1;
      if (start_det) begin
        if (cfg_data_bits < 4'd5)                   nbits <= 4'd5;
        else if (cfg_data_bits > 4'(MAX_WIDTH))     nbits <= 4'(MAX_WIDTH);
        else                                        nbits <= cfg_data_bits;
        par_mode  <= cfg_parity;
        two_stop  <= (cfg_stop_bits == 2'b10) || (cfg_stop_bits == 2'b11);
        smp <= '0; bit_idx <= '0; stop_idx <= 1'b0; data_q <= '0;
        par_err_q <= 1'b0; frm_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        any_one_q <= 1'b0;
`endif
      end else if (tick) begin
        smp <= (smp == S_END) ? '0 : smp + 1'b1;
        if (smp == S_LO)  s_a <= rx_s;
        if (smp == S_MID) s_b <= rx_s;
        if (at_vote) begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (state != START) any_one_q <= any_one_q | vote;
`endif
          case (state)
            DATA: begin
              for (int i = 0; i < MAX_WIDTH; i++)
                if (bit_idx == 4'(i)) data_q[i] <= vote;
              bit_idx <= bit_idx + 4'd1;
            end
            PARITY:  par_err_q <= ((^data_q) ^ vote) != (par_mode == 2'b01);
            STOP:    frm_err_q <= frm_err_q | ~vote;
            default: ;
          endcase
        end
        if (at_end && state == STOP) stop_idx <= 1'b1;
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q;
  logic [EW-1:0] head, push_entry;
  logic pop, accept;

  assign push_entry = {data_q, par_err_q, frm_err_q | ~vote};
  assign pop        = rx_req && (count_q != '0);
  assign accept     = push && ((count_q != DEPTH) || pop);
  assign head       = mem[rd_ptr];
  assign rx_ready   = (count_q != '0);
  assign rx_count   = count_q;
  assign rx_data       = rx_ready ? head[EW-1:2] : '0;
  assign rx_parity_err = rx_ready & head[1];
  assign rx_frame_err  = rx_ready & head[0];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0; count_q <= '0; overrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !accept) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= brk;
  end
`else
  assign break_det = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - Randomized self-checking bench for uart_rx_ovs against a frame-level reference model
module tb_uart_rx_ovs;
  localparam int MW = 8, SR = 16, FD = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00, cfg_stop_bits = 2'b00;
  logic [15:0] cfg_clk_div = 16'd4;
  logic uart_rx = 1'b1, rx_req = 1'b0, clr_overrun = 1'b0;
  logic [MW-1:0] rx_data;
  logic rx_ready, rx_parity_err, rx_frame_err, overrun, break_det;
  logic [3:0] rx_count;

  uart_rx_ovs #(.MAX_WIDTH(MW), .SAMPLE_RATE(SR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop_bits(cfg_stop_bits), .cfg_clk_div(cfg_clk_div), .uart_rx(uart_rx),
    .rx_req(rx_req), .rx_data(rx_data), .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .overrun(overrun), .clr_overrun(clr_overrun),
    .break_det(break_det), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_checks = 0, n_fail = 0;
  int t_start = 0, t_ready = -1, lat = 0, brk_pulses = 0;
  logic prev_rdy = 1'b0;
  logic [MW+1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_ready && !prev_rdy) t_ready = cyc;
    prev_rdy = rx_ready;
    if (break_det) brk_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1);
  end

  function automatic logic [MW+1:0] model(input logic [7:0] d, input int nb, input logic [1:0] par,
                                          input logic [1:0] stp, input bit bad_p, input bit bad_s1, input bit bad_s2);
    logic [7:0] m;
    m = 8'((1 << nb) - 1);
    return {d & m, (par == 2'b01 || par == 2'b10) && bad_p, bad_s1 || (stp[1] && bad_s2)};
  endfunction

  task automatic drive_bit(input logic v, input int blen, input int dv, input bit g);
    for (int c = 0; c < blen; c++) begin
      // A flip shorter than one tick period can corrupt at most one of the three votes.
      uart_rx = (g && c >= blen / 2 - dv / 2 && c < blen / 2 - dv / 2 + dv - 1) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] par, input logic [1:0] stp,
                            input bit bad_p, input bit bad_s1, input bit bad_s2, input int div,
                            input bit glitch, input bit scramble);
    int dv, blen;
    logic [7:0] m;
    logic pb;
    dv = (div < 1) ? 1 : div;
    blen = SR * dv;
    m = 8'((1 << nb) - 1);
    cfg_clk_div = 16'(div); cfg_data_bits = 4'(nb); cfg_parity = par; cfg_stop_bits = stp;
    @(negedge clk);
    t_start = cyc;
    drive_bit(1'b0, blen, dv, glitch);
    if (scramble) begin
      cfg_data_bits = 4'($urandom_range(5, 8)); cfg_parity = 2'($urandom); cfg_stop_bits = 2'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(d[i], blen, dv, glitch);
    if (par == 2'b01 || par == 2'b10) begin
      pb = (^(d & m)) ^ (par == 2'b01) ^ bad_p;
      drive_bit(pb, blen, dv, glitch);
    end
    drive_bit(!bad_s1, blen, dv, 1'b0);
    if (stp[1]) drive_bit(!bad_s2, blen, dv, 1'b0);
    drive_bit(1'b1, blen, dv, 1'b0);
    cfg_data_bits = 4'(nb); cfg_parity = par; cfg_stop_bits = stp;
  endtask

  task automatic pop_entry(output logic rdy, output logic [MW+1:0] ent);
    rdy = rx_ready;
    ent = {rx_data, rx_parity_err, rx_frame_err};
    rx_req = 1'b1;
    @(negedge clk);
    rx_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rx_ready); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++; if ({rx_parity_err, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {rx_parity_err, rx_frame_err}); end
    n_checks++; if ({overrun, break_det} !== 2'b00) begin n_fail++; $display("FAIL reset_ovr_brk: got %b expected 00", {overrun, break_det}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1;
    logic rdy;
    logic [MW+1:0] ent;
    send_frame(8'hA5, 8, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0);
    lat = t_ready - t_start;
    n_checks++; if (!(lat > 0 && lat < 11 * SR * 4)) begin n_fail++; $display("FAIL calib_latency: got %0d expected 1..%0d", lat, 11 * SR * 4 - 1); end
    n_checks++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL 8n1_count: got %0d expected 1", rx_count); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h expected a5", rx_data); end
    n_checks++; if ({rx_parity_err, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL 8n1_flags: got %b expected 00", {rx_parity_err, rx_frame_err}); end
    pop_entry(rdy, ent);
    n_checks++; if (rx_count !== 4'd0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL 8n1_pop: count %0d ready %b expected 0 0", rx_count, rx_ready); end
  endtask

  task automatic test_7e2_errors;
    logic rdy;
    logic [MW+1:0] ent, exp;
    exp = model(8'h35, 7, 2'b10, 2'b10, 1, 0, 1);
    send_frame(8'h35, 7, 2'b10, 2'b10, 1, 0, 1, 4, 0, 0);
    pop_entry(rdy, ent);
    n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL 7e2_err: ready %b entry %h expected 1 %h", rdy, ent, exp); end
  endtask

  task automatic test_random;
    logic rdy;
    logic [MW+1:0] ent, exp;
    logic [7:0] d, m;
    int nb, div;
    logic [1:0] par, stp;
    bit bp, b1, b2;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 2; k++) begin
        nb = $urandom_range(5, 8); par = 2'($urandom); stp = 2'($urandom);
        bp = 1'($urandom); b1 = ($urandom_range(0, 3) == 0); b2 = ($urandom_range(0, 3) == 0);
        div = $urandom_range(0, 5); d = 8'($urandom);
        m = 8'((1 << nb) - 1);
        if ((d & m) == 8'h00) d[0] = 1'b1;
        exp_q.push_back(model(d, nb, par, stp, bp, b1, b2));
        send_frame(d, nb, par, stp, bp, b1, b2, div, 0, 1);
      end
      n_checks++; if (rx_count !== 4'd2) begin n_fail++; $display("FAIL rand_count pair %0d: got %0d expected 2", p, rx_count); end
      for (int k = 0; k < 2; k++) begin
        exp = exp_q.pop_front();
        pop_entry(rdy, ent);
        n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL rand_entry pair %0d/%0d: ready %b entry %h expected 1 %h", p, k, rdy, ent, exp); end
      end
    end
  endtask

  task automatic test_overrun_and_full_pop;
    logic rdy;
    logic [MW+1:0] ent, exp, head_exp;
    logic [7:0] d;
    int tgt;
    for (int f = 0; f < 9; f++) begin
      d = 8'($urandom_range(1, 255));
      if (f < FD) exp_q.push_back(model(d, 8, 2'b00, 2'b00, 0, 0, 0));
      send_frame(d, 8, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0);
      if (f == FD - 1) begin
        n_checks++; if (rx_count !== 4'd8 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_fill: count %0d overrun %b expected 8 0", rx_count, overrun); end
      end
    end
    n_checks++; if (rx_count !== 4'd8 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_drop: count %0d overrun %b expected 8 1", rx_count, overrun); end
    clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    head_exp = exp_q.pop_front();
    d = 8'h6E;
    exp_q.push_back(model(d, 8, 2'b00, 2'b00, 0, 0, 0));
    fork
      send_frame(d, 8, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0);
      begin
        repeat (2) @(negedge clk);
        tgt = t_start + lat - 1;
        while (cyc < tgt) @(negedge clk);
        n_checks++; if ({rx_data, rx_parity_err, rx_frame_err} !== head_exp) begin n_fail++; $display("FAIL full_pop_head: got %h expected %h", {rx_data, rx_parity_err, rx_frame_err}, head_exp); end
        rx_req = 1'b1; @(negedge clk); rx_req = 1'b0;
      end
    join
    n_checks++; if (rx_count !== 4'd8 || overrun !== 1'b0) begin n_fail++; $display("FAIL full_pop: count %0d overrun %b expected 8 0", rx_count, overrun); end
    for (int k = 0; k < FD; k++) begin
      exp = exp_q.pop_front();
      pop_entry(rdy, ent);
      n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL drain_entry %0d: ready %b entry %h expected 1 %h", k, rdy, ent, exp); end
    end
    n_checks++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got %0d expected 0", rx_count); end
  endtask

  task automatic test_glitch;
    logic rdy;
    logic [MW+1:0] ent, exp;
    cfg_clk_div = 16'd8;
    uart_rx = 1'b0; repeat (3 * 8) @(negedge clk);
    uart_rx = 1'b1; repeat (3 * SR * 8) @(negedge clk);
    n_checks++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL false_start: count %0d expected 0", rx_count); end
    exp = model(8'h96, 8, 2'b01, 2'b00, 0, 0, 0);
    send_frame(8'h96, 8, 2'b01, 2'b00, 0, 0, 0, 8, 1, 0);
    pop_entry(rdy, ent);
    n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL glitch_frame: ready %b entry %h expected 1 %h", rdy, ent, exp); end
  endtask

  task automatic test_break;
    logic rdy;
    logic [MW+1:0] ent, exp;
    cfg_clk_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop_bits = 2'b00;
    brk_pulses = 0;
    uart_rx = 1'b0; repeat (2 * 10 * SR * 4) @(negedge clk);
    uart_rx = 1'b1; repeat (2 * SR * 4) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    n_checks++; if (brk_pulses !== 1) begin n_fail++; $display("FAIL break_pulse: got %0d pulses expected 1", brk_pulses); end
    n_checks++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL break_nopush: count %0d expected 0", rx_count); end
`else
    n_checks++; if (brk_pulses !== 0) begin n_fail++; $display("FAIL break_tied: got %0d pulses expected 0", brk_pulses); end
    pop_entry(rdy, ent);
    n_checks++; if (rdy !== 1'b1 || ent !== {8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL break_frame: ready %b entry %h expected 1 %h", rdy, ent, {8'h00, 1'b0, 1'b1}); end
`endif
    exp = model(8'h3C, 8, 2'b00, 2'b00, 0, 0, 0);
    send_frame(8'h3C, 8, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0);
    pop_entry(rdy, ent);
    n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL after_break: ready %b entry %h expected 1 %h", rdy, ent, exp); end
  endtask

  task automatic test_reset_midframe;
    logic rdy;
    logic [MW+1:0] ent, exp;
    cfg_clk_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop_bits = 2'b00;
    uart_rx = 1'b0; repeat (3 * SR * 4) @(negedge clk);
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    repeat (SR * 4) @(negedge clk);
    uart_rx = 1'b1; repeat (12 * SR * 4) @(negedge clk);
    n_checks++; if (rx_count !== 4'd0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_abort: count %0d ready %b expected 0 0", rx_count, rx_ready); end
    exp = model(8'h5A, 8, 2'b00, 2'b00, 0, 0, 0);
    send_frame(8'h5A, 8, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0);
    pop_entry(rdy, ent);
    n_checks++; if (rdy !== 1'b1 || ent !== exp) begin n_fail++; $display("FAIL rst_resume: ready %b entry %h expected 1 %h", rdy, ent, exp); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2_errors();
    test_random();
    test_overrun_and_full_pop();
    test_glitch();
    test_break();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 8: widest data field supported (5..9).
REQ-002 SHALL have parameter SAMPLE_RATE, default 16: sample ticks per bit; even, >=4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries; power of 2, >=2.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port cfg_data_bits  input  4  data bits per frame, 5..MAX_WIDTH.
REQ-007 SHALL have port cfg_parity  input  2  parity mode: 00/11 none, 01 odd, 10 even.
REQ-008 SHALL have port cfg_stop_bits  input  2  stop bits: 00/01 one, 10/11 two.
REQ-009 SHALL have port cfg_clk_div  input  16  clk cycles per sample tick; 0 is treated as 1.
REQ-010 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-011 SHALL have port rx_req  input  1  pop request for the FIFO head.
REQ-012 SHALL have port rx_data  output  MAX_WIDTH  FIFO head data, zero-extended above cfg_data_bits.
REQ-013 SHALL have port rx_ready  output  1  FIFO non-empty.
REQ-014 SHALL have port rx_parity_err  output  1  parity-error flag stored with the head entry.
REQ-015 SHALL have port rx_frame_err  output  1  stop-bit error flag stored with the head entry.
REQ-016 SHALL have port overrun  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-017 SHALL have port clr_overrun  input  1  clears overrun.
REQ-018 SHALL have port break_det  output  1  one-cycle pulse on a detected line break.
REQ-019 SHALL have port rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 SHALL pass uart_rx through a 2-flop synchronizer; all decoding uses the synchronized signal.
REQ-021 SHALL emit one sample tick every max(cfg_clk_div,1) clk cycles; the tick counter runs only outside IDLE and restarts on start detection.
REQ-022 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-023 SHALL leave IDLE for START on a synchronized 1->0 transition, latching cfg_data_bits, cfg_parity and cfg_stop_bits; config changes mid-frame SHALL have no effect on that frame.
REQ-024 SHALL decide each bit by 2-of-3 majority vote of samples at ticks SAMPLE_RATE/2-1, SAMPLE_RATE/2 and SAMPLE_RATE/2+1 of that bit.
REQ-025 SHALL treat a start-bit vote of 1 as a false start and return to IDLE with no push.
REQ-026 SHALL shift data LSB first for exactly the latched data-bit count, then enter PARITY if parity is enabled, else STOP.
REQ-027 SHALL set the entry's parity error when the received parity bit mismatches odd/even parity over the data bits.
REQ-028 SHALL set the entry's frame error if any stop-bit vote is 0; the second stop bit SHALL be checked only when two stop bits are configured.
REQ-029 SHALL push {data, parity_err, frame_err} at the final stop-bit vote tick and return to IDLE at that point, not at the bit end.
REQ-030 SHALL raise rx_ready the cycle after the push into an empty FIFO; rx_data and flags SHALL be show-ahead (valid whenever rx_ready=1).
REQ-031 SHALL pop on rx_req && rx_ready; rx_req while empty SHALL be ignored.
REQ-032 SHALL accept a push when rx_count<FIFO_DEPTH or a pop occurs in the same cycle; otherwise it SHALL drop the frame and set overrun.
REQ-033 SHALL on simultaneous push and pop leave rx_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 SHALL give set priority over clr_overrun when both occur in the same cycle.

Reset
REQ-035 SHALL on rst set: FSM IDLE, synchronizer flops 1, FIFO empty, rx_count 0, rx_ready 0, rx_data 0, rx_parity_err 0, rx_frame_err 0, overrun 0, break_det 0.
REQ-036 SHALL on rst asserted mid-frame abort the frame without a push; reception SHALL resume only on a new falling edge after rst deasserts.

Configuration
REQ-037 SHALL compile break detection in when macro UART_RX_BREAK_DETECT_EN is defined: a frame whose data, parity and stop votes are all 0 SHALL pulse break_det for one cycle, push nothing, and wait in BRK_WAIT until the synchronized line is 1, then go to IDLE.
REQ-038 SHALL without UART_RX_BREAK_DETECT_EN tie break_det to 0, omit BRK_WAIT, and push such a frame as data 0 with frame_err=1.

Verification
REQ-039 SHALL cover: 8N1, cfg_clk_div=4, byte 0xA5 -> rx_data=0xA5, both error flags 0, rx_count=1.
REQ-040 SHALL cover: 7E2, data 0x35 sent with wrong parity and second stop bit 0 -> rx_data=0x35, rx_parity_err=1, rx_frame_err=1.
REQ-041 SHALL cover: 9 frames into FIFO_DEPTH=8 with no pops -> first 8 stored in order, overrun=1, 9th dropped; clr_overrun -> overrun=0.
REQ-042 SHALL cover: 3-tick low glitch on idle line -> false start, no push; one flipped middle sample per bit -> frame decoded correctly.
REQ-043 SHALL cover: with macro, line held 0 for 2 frame times -> one break_det pulse, no push, next frame 0x3C received correctly after line returns high.
REQ-044 SHALL cover: FIFO full, rx_req held while a frame completes -> push accepted, rx_count stays 8, overrun stays 0.
